cam_pixel_capture: RTL
======================

// Module: cam_pixel_capture
// PURPOSE
//  Parametrised DVP camera capture for OV7670-class sensors; sits between the camera pins and the pixel sink.
//  - Samples pclk/vsync/href/data in the system clk domain; assembles BYTES_PER_PIX bytes per pixel.
//  - Emits pixels with row/col coordinates, frame framing pulses, geometry-error flags and a frame counter.
// PARAMETERS
//  DATA_W         8    camera data bus width
//  BYTES_PER_PIX  2    bytes per pixel (1..4)
//  COLS           320  expected pixels per line
//  ROWS           240  expected lines per frame
//  SYNC_STAGES    2    synchroniser depth on all camera inputs (>=2)
//  MSB_FIRST      1    1: first byte of pixel -> pix_data MSbyte; 0: first byte -> LSbyte
// PORTS
//  clk          in   1                   system clock; must be >= 4x pclk
//  reset        in   1                   active-low synchronous reset
//  enable       in   1                   arm capture; sampled at frame boundaries
//  cam_pclk     in   1                   camera pixel clock (sampled as data)
//  cam_vsync    in   1                   high = vertical blanking
//  cam_href     in   1                   high = active line bytes
//  cam_data     in   DATA_W              camera byte
//  pix_valid    out  1                   1-cycle pulse, pix_data/col/row valid
//  pix_data     out  DATA_W*BYTES_PER_PIX assembled pixel
//  pix_col      out  $clog2(COLS)        column of pixel
//  pix_row      out  $clog2(ROWS)        row of pixel
//  frame_start  out  1                   pulse, coincident with pix_valid of (0,0)
//  frame_done   out  1                   pulse at end of frame
//  geom_err     out  1                   pulse: line/frame length mismatch
//  frame_count  out  16                  completed frames, wraps FFFF->0000
// BEHAVIOUR
//  - Reset (reset==0 at posedge clk): all outputs 0, state IDLE, counters 0, synchronisers cleared.
//  - cam_* inputs pass through SYNC_STAGES flops together; byte strobe = synced pclk rising edge (1 clk).
//  - States: IDLE -(enable)-> WAIT_VS -(synced vsync falling)-> FRAME -(synced vsync rising)-> WAIT_VS if enable else IDLE.
//  - WAIT_VS entered mid-frame never captures that partial frame; first capture is always a full frame.
//  - FRAME: strobe with href=1 stores byte at byte_idx, byte_idx++; at BYTES_PER_PIX-th byte byte_idx->0,
//    pix_valid pulses next cycle with current col/row, then col++.
//  - Latency: pix_valid exactly SYNC_STAGES+2 clk after the pin-level pclk rise of the pixel's last byte.
//  - Synced href falling: geom_err pulse if col!=COLS or byte_idx!=0; row++, col=0, byte_idx=0.
//  - col saturates at COLS: further pixels on that line dropped (no pix_valid), flagged at line end.
//  - row saturates at ROWS: further lines dropped, no pix_valid.
//  - vsync rising in FRAME: frame_done pulse, frame_count++; geom_err pulse if row!=ROWS.
//    If href still high, the partial line is discarded and flagged via the same geom_err pulse (single pulse).
//  - enable deasserted in FRAME: current frame completes normally, then IDLE.
//  - enable only gates WAIT_VS entry; toggling it inside FRAME has no effect on that frame.
//  - Reset mid-frame: immediate return to IDLE; no frame_done; frame_count cleared.
//  - pix_data/col/row hold last value between pix_valid pulses.
// CONFIGURATION
//  CAM_CAPTURE_CROP_EN defined: adds inputs crop_x0, crop_x1 ($clog2(COLS)) and crop_y0, crop_y1 ($clog2(ROWS)),
//   sampled at vsync falling. pix_valid only for crop_x0<=col<=crop_x1 and crop_y0<=row<=crop_y1.
//   pix_col/pix_row stay absolute sensor coordinates; frame_start on first in-window pixel.
//   geom_err still checks the full COLS/ROWS geometry.
//  Not defined: no crop ports; every in-range pixel emitted.
// TESTING
//  1. COLS=4,ROWS=2, 2B/pix, bytes 0x12,0x34 per pixel, MSB_FIRST=1 -> 8 pix_valid, pix_data=16'h1234,
//     (col,row) 0..3 x 0..1, frame_start with (0,0), frame_done once, frame_count=1, no geom_err.
//  2. Line with 5 pixels (COLS=4) -> 4 pix_valid, 5th dropped, geom_err pulse at href fall.
//  3. Odd byte count (7 bytes) on a line -> 3 pix_valid, geom_err at href fall.
//  4. enable asserted mid-frame -> no pix_valid until after the next vsync falling.
//  5. enable deasserted mid-frame -> frame finishes, frame_count++, then IDLE.
//  6. Reset mid-frame, then a clean frame -> frame_count=1.
//  7. CROP_EN, window x1..2,y1 -> exactly 2 pix_valid at (1,1),(2,1), frame_start at (1,1).

Source files
------------

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: DVP (OV7670-class) camera capture in the system clock domain.
// Camera pins are synchronised, pclk rising edges become byte strobes, bytes are
// assembled into pixels and emitted with row/col coordinates, framing pulses,
// geometry-error flags and a completed-frame counter.
// Optional crop window: define CAM_CAPTURE_CROP_EN to add crop_x0/x1/y0/y1 inputs.
module cam_pixel_capture #(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int COLS          = 320,
   parameter int ROWS          = 240,
   parameter int SYNC_STAGES   = 2,
   parameter int MSB_FIRST     = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              cam_pclk,
   input  logic                              cam_vsync,
   input  logic                              cam_href,
   input  logic [DATA_W-1:0]                 cam_data,
`ifdef CAM_CAPTURE_CROP_EN
   input  logic [$clog2(COLS)-1:0]           crop_x0,
   input  logic [$clog2(COLS)-1:0]           crop_x1,
   input  logic [$clog2(ROWS)-1:0]           crop_y0,
   input  logic [$clog2(ROWS)-1:0]           crop_y1,
`endif
   output logic                              pix_valid,
   output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data,
   output logic [$clog2(COLS)-1:0]           pix_col,
   output logic [$clog2(ROWS)-1:0]           pix_row,
   output logic                              frame_start,
   output logic                              frame_done,
   output logic                              geom_err,
   output logic [15:0]                       frame_count
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int PW = DATA_W * BYTES_PER_PIX;
   localparam int BW = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

   localparam logic [CW:0]   COLS_L = (CW+1)'(COLS);
   localparam logic [RW:0]   ROWS_L = (RW+1)'(ROWS);
   localparam logic [BW-1:0] LAST_B = BW'(BYTES_PER_PIX - 1);

   typedef enum logic [1:0] {IDLE, WAIT_VS, FRAME} state_t;

   // synchroniser chains and edge-detect history
   logic [SYNC_STAGES-1:0]        pclk_sr, vsync_sr, href_sr;
   logic [SYNC_STAGES*DATA_W-1:0] data_sr;
   logic                          pclk_s, vsync_s, href_s;
   logic [DATA_W-1:0]             data_s;
   logic                          pclk_q, vsync_q, href_q;
   logic                          strobe, vs_rise, vs_fall, href_fall;

   state_t state, state_nx;
   logic   frame_entry;

   // capture counters: one extra bit so col/row can sit at COLS/ROWS (saturated)
   logic [CW:0]     col;
   logic [RW:0]     row;
   logic [BW-1:0]   byte_idx;
   logic            line_ovf, frame_ovf;
   logic [PW-1:0]   bytes_q, pix_asm;
   logic [DATA_W-1:0] byte_sel;

   // completed pixel waiting for the output register
   logic            pend;
   logic [PW-1:0]   pend_data;
   logic [CW-1:0]   pend_col;
   logic [RW-1:0]   pend_row;
   logic            in_win;

`ifdef CAM_CAPTURE_CROP_EN
   logic [CW-1:0]   x0_q, x1_q;
   logic [RW-1:0]   y0_q, y1_q;
   logic            started;
`endif

   assign pclk_s    = pclk_sr[SYNC_STAGES-1];
   assign vsync_s   = vsync_sr[SYNC_STAGES-1];
   assign href_s    = href_sr[SYNC_STAGES-1];
   assign data_s    = data_sr[SYNC_STAGES*DATA_W-1 -: DATA_W];

   assign strobe    = pclk_s & ~pclk_q;
   assign vs_rise   = vsync_s & ~vsync_q;
   assign vs_fall   = ~vsync_s & vsync_q;
   assign href_fall = ~href_s & href_q;

`ifdef CAM_CAPTURE_CROP_EN
   assign in_win = (col >= {1'b0, x0_q}) && (col <= {1'b0, x1_q}) &&
                   (row >= {1'b0, y0_q}) && (row <= {1'b0, y1_q});
`else
   assign in_win = 1'b1;
`endif

   // Synchronise all camera inputs together and keep one cycle of history for edges
   always_ff @(posedge clk) begin
      if (!reset) begin
         pclk_sr  <= '0;
         vsync_sr <= '0;
         href_sr  <= '0;
         data_sr  <= '0;
         pclk_q   <= 1'b0;
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
      end else begin
         pclk_sr  <= {pclk_sr[SYNC_STAGES-2:0], cam_pclk};
         vsync_sr <= {vsync_sr[SYNC_STAGES-2:0], cam_vsync};
         href_sr  <= {href_sr[SYNC_STAGES-2:0], cam_href};
         data_sr  <= {data_sr[(SYNC_STAGES-1)*DATA_W-1:0], cam_data};
         pclk_q   <= pclk_s;
         vsync_q  <= vsync_s;
         href_q   <= href_s;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: enable is only looked at when leaving IDLE or closing a frame
   always_comb begin
      state_nx    = state;
      frame_entry = 1'b0;
      case (state)
         IDLE:    if (enable) state_nx = WAIT_VS;
         WAIT_VS: if (vs_fall) begin
                     state_nx    = FRAME;
                     frame_entry = 1'b1;
                  end
         FRAME:   if (vs_rise) state_nx = enable ? WAIT_VS : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Pixel word as it will look once the byte currently on the bus is stored
   always_comb begin
      pix_asm  = '0;
      byte_sel = '0;
      for (int unsigned i = 0; i < BYTES_PER_PIX; i++) begin
         byte_sel = (i == 32'(byte_idx)) ? data_s : bytes_q[i*DATA_W +: DATA_W];
         if (MSB_FIRST != 0) pix_asm[(BYTES_PER_PIX-1-i)*DATA_W +: DATA_W] = byte_sel;
         else                pix_asm[i*DATA_W +: DATA_W]                   = byte_sel;
      end
   end

   // Frame/line/byte bookkeeping, geometry checks and frame counting
   always_ff @(posedge clk) begin
      if (!reset) begin
         col         <= '0;
         row         <= '0;
         byte_idx    <= '0;
         line_ovf    <= 1'b0;
         frame_ovf   <= 1'b0;
         bytes_q     <= '0;
         pend        <= 1'b0;
         pend_data   <= '0;
         pend_col    <= '0;
         pend_row    <= '0;
         frame_done  <= 1'b0;
         geom_err    <= 1'b0;
         frame_count <= '0;
`ifdef CAM_CAPTURE_CROP_EN
         x0_q        <= '0;
         x1_q        <= '0;
         y0_q        <= '0;
         y1_q        <= '0;
`endif
      end else begin
         pend       <= 1'b0;
         frame_done <= 1'b0;
         geom_err   <= 1'b0;
         if (frame_entry) begin
            col       <= '0;
            row       <= '0;
            byte_idx  <= '0;
            line_ovf  <= 1'b0;
            frame_ovf <= 1'b0;
`ifdef CAM_CAPTURE_CROP_EN
            x0_q      <= crop_x0;
            x1_q      <= crop_x1;
            y0_q      <= crop_y0;
            y1_q      <= crop_y1;
`endif
         end else if (state == FRAME) begin
            if (vs_rise) begin
               // a line still open here is a truncated line; folded into the one pulse
               frame_done  <= 1'b1;
               frame_count <= frame_count + 16'd1;
               geom_err    <= (row != ROWS_L) || href_s || frame_ovf;
               col         <= '0;
               byte_idx    <= '0;
               line_ovf    <= 1'b0;
            end else if (href_fall) begin
               geom_err <= (col != COLS_L) || (byte_idx != '0) || line_ovf;
               if (row == ROWS_L) frame_ovf <= 1'b1;
               else               row       <= row + 1'b1;
               col      <= '0;
               byte_idx <= '0;
               line_ovf <= 1'b0;
            end else if (strobe && href_s) begin
               bytes_q[byte_idx*DATA_W +: DATA_W] <= data_s;
               if (byte_idx == LAST_B) begin
                  byte_idx <= '0;
                  if (col == COLS_L) begin
                     line_ovf <= 1'b1;
                  end else begin
                     col <= col + 1'b1;
                     if ((row != ROWS_L) && in_win) begin
                        pend      <= 1'b1;
                        pend_data <= pix_asm;
                        pend_col  <= col[CW-1:0];
                        pend_row  <= row[RW-1:0];
                     end
                  end
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
         end
      end
   end

   // Output register: one-cycle pix_valid, data/coordinates hold between pulses
   always_ff @(posedge clk) begin
      if (!reset) begin
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_col     <= '0;
         pix_row     <= '0;
         frame_start <= 1'b0;
`ifdef CAM_CAPTURE_CROP_EN
         started     <= 1'b0;
`endif
      end else begin
         pix_valid   <= pend;
         frame_start <= 1'b0;
         if (pend) begin
            pix_data <= pend_data;
            pix_col  <= pend_col;
            pix_row  <= pend_row;
`ifdef CAM_CAPTURE_CROP_EN
            frame_start <= ~started;
`else
            frame_start <= (pend_col == '0) && (pend_row == '0);
`endif
         end
`ifdef CAM_CAPTURE_CROP_EN
         if (frame_entry) started <= 1'b0;
         else if (pend)   started <= 1'b1;
`endif
      end
   end

endmodule
